aes_key_expand_seq: RTL

//  Sequential AES key-schedule engine; successor to the combinational KeyExpansion.

---
 rtl/aes_key_expand_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per clock, full schedule held for random round-key reads.
// Optional KEY_EXP_STREAM_EN adds a round-key stream port that emits each round key as soon as it is complete.
module aes_key_expand_seq #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             key_valid,
  input  logic [3:0]       rk_idx,
  output logic [127:0]     rk_out
`ifdef KEY_EXP_STREAM_EN
  ,
  output logic             rk_strm_valid,
  output logic [3:0]       rk_strm_idx,
  output logic [127:0]     rk_strm
`endif
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = 6;
  localparam int KW = $clog2(NK);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_key_expand_seq: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_kv;
  logic [7:0]    r_rcon;
  logic [IW-1:0] r_i;
  logic [2:0]    r_mod;
  logic [31:0]   r_w [NW];

  logic          w_accept;
  logic [31:0]   w_key [NK];
  logic [31:0]   w_prev;
  logic [31:0]   w_old;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub;
  logic [31:0]   w_t;
  logic [31:0]   w_new;
  logic [7:0]    w_xtime;

  assign busy      = r_busy;
  assign done      = r_done;
  assign key_valid = r_kv;
  assign w_accept  = start & ~r_busy;
  assign w_xtime   = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  for (genvar k = 0; k < NK; k++) begin : g_key
    assign w_key[k] = key_in[32*(NK-1-k) +: 32];
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign w_sub[8*b +: 8] = SBOX[w_sub_in[8*b +: 8]];
  end

  // r_mod tracks i % NK so NK=6 needs no divider.
  always_comb begin
    w_prev   = r_w[r_i - 6'd1];
    w_old    = r_w[r_i - 6'(NK)];
    w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    if (r_mod == 3'd0)
      w_t = w_sub ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_mod == 3'd4)
      w_t = w_sub;
    else
      w_t = w_prev;
    w_new = w_old ^ w_t;
  end

`ifdef KEY_EXP_STREAM_EN
  logic [3:0] r_sr;
  logic       w_strm_valid;

  // A round streams once all four of its words sit in storage; r_i counts words written.
  assign w_strm_valid  = (r_state != IDLE) && (r_sr <= 4'(NR)) &&
                         (r_i >= ({r_sr, 2'b00} + 6'd4));
  assign rk_strm_valid = w_strm_valid;
  assign rk_strm_idx   = r_sr;
  assign rk_strm       = {r_w[{r_sr, 2'd0}], r_w[{r_sr, 2'd1}],
                          r_w[{r_sr, 2'd2}], r_w[{r_sr, 2'd3}]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sr <= '0;
    else if (w_accept)
      r_sr <= '0;
    else if (w_strm_valid)
      r_sr <= r_sr + 4'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_kv    <= 1'b0;
      r_rcon  <= 8'h01;
      r_i     <= '0;
      r_mod   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= EXPAND;
            r_busy  <= 1'b1;
            r_kv    <= 1'b0;
            r_i     <= 6'(NK);
            r_mod   <= '0;
            r_rcon  <= 8'h01;
          end
        end
        EXPAND: begin
          r_i   <= r_i + 6'd1;
          r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
          if (r_mod == 3'd0)
            r_rcon <= w_xtime;
          if (r_i == 6'(NW - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_kv    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned k = 0; k < NK; k++)
        r_w[k[IW-1:0]] <= w_key[k[KW-1:0]];
    end else if (r_state == EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  always_comb begin
    rk_out = '0;
    if (rk_idx <= 4'(NR))
      rk_out = {r_w[{rk_idx, 2'd0}], r_w[{rk_idx, 2'd1}],
                r_w[{rk_idx, 2'd2}], r_w[{rk_idx, 2'd3}]};
  end

endmodule
